// File: rtl/fpu_issue_controller.sv
// Issue controller for a multi-cycle fixed-point unit: accepts one request,
// sequences it through execution with minimum-latency and timeout rules, then holds the writeback.
module fpu_issue_controller #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_MIN  = 7,
  parameter int unsigned SQRT_MIN = 36,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [4:0]       req_rd,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_error,
  output logic             busy
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned TAG_W   = 5;

  localparam logic [OP_W-1:0] FPU_ADD  = 2'd0;
  localparam logic [OP_W-1:0] FPU_SUB  = 2'd1;
  localparam logic [OP_W-1:0] FPU_MUL  = 2'd2;
  localparam logic [OP_W-1:0] FPU_SQRT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MUL_LAT   = CNT_W'(MUL_MIN);
  localparam logic [CNT_W-1:0] SQRT_LAT  = CNT_W'(SQRT_MIN);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [WIDTH-1:0]   opnd1_q, opnd1_d;
  logic [WIDTH-1:0]   opnd2_q, opnd2_d;
  logic [OP_W-1:0]    fpu_op_q, fpu_op_d;
  logic               wb_valid_q, wb_valid_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic [TAG_W-1:0]   wb_rd_q, wb_rd_d;
  logic               wb_error_q, wb_error_d;

  logic [CNT_W-1:0]   min_lat_c;
  logic               done_c;
  logic               timeout_c;

  // Minimum latency for the in-flight op; fpu_ready before this count may be stale.
  always_comb begin
    min_lat_c = '0;
    case (op_q)
      FPU_MUL:  min_lat_c = MUL_LAT;
      FPU_SQRT: min_lat_c = SQRT_LAT;
      FPU_ADD,
      FPU_SUB:  min_lat_c = '0;
      default:  min_lat_c = '0;
    endcase
  end

  assign done_c    = fpu_ready && (cnt_q >= min_lat_c);
  assign timeout_c = (cnt_q == TIMEOUT_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= FPU_ADD;
      opnd1_q    <= '0;
      opnd2_q    <= '0;
      fpu_op_q   <= FPU_ADD;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opnd1_q    <= opnd1_d;
      opnd2_q    <= opnd2_d;
      fpu_op_q   <= fpu_op_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_error_q <= wb_error_d;
    end
  end

  // Next-state and registered-output update; completion takes priority over timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opnd1_d    = opnd1_q;
    opnd2_d    = opnd2_q;
    fpu_op_d   = fpu_op_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_error_d = wb_error_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          opnd1_d  = req_rs1;
          opnd2_d  = req_rs2;
          op_d     = req_op;
          fpu_op_d = req_op;
          wb_rd_d  = req_rd;
          cnt_d    = '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done_c) begin
          wb_data_d  = fpu_result;
          wb_error_d = 1'b0;
          wb_valid_d = 1'b1;
          fpu_op_d   = FPU_ADD;
          state_d    = WB;
        end else if (timeout_c) begin
          wb_data_d  = '0;
          wb_error_d = 1'b1;
          wb_valid_d = 1'b1;
          fpu_op_d   = FPU_ADD;
          state_d    = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        wb_valid_d = 1'b0;
        fpu_op_d   = FPU_ADD;
      end
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign fpu_operand_1 = opnd1_q;
  assign fpu_operand_2 = opnd2_q;
  assign fpu_operation = fpu_op_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_error      = wb_error_q;

endmodule

// File: doc/fpu_issue_controller.md
FPU_ISSUE_CONTROLLER -- requirements
Module: fpu_issue_controller

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter MUL_MIN, default 7, minimum EXEC cycle count before fpu_ready is honoured for MUL.
REQ-003 Parameter SQRT_MIN, default 36, minimum EXEC cycle count before fpu_ready is honoured for SQRT.
REQ-004 Parameter TIMEOUT, default 255 (max 255), EXEC cycle count at which the operation is aborted.
REQ-005 Reset is reset, asynchronous, active-high; the clock is clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 req_valid  input  1  issue request present.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 req_op  input  2  operation, FPU_ADD/FPU_SUB/FPU_MUL/FPU_SQRT encodings from Defines.vh.
REQ-011 req_rs1, req_rs2  input  WIDTH each  source operands.
REQ-012 req_rd  input  5  destination register tag.
REQ-013 fpu_operand_1, fpu_operand_2  output  WIDTH each  operands to the fixed-point unit.
REQ-014 fpu_operation  output  2  operation code to the fixed-point unit.
REQ-015 fpu_result  input  WIDTH  result from the fixed-point unit.
REQ-016 fpu_ready  input  1  completion flag from the fixed-point unit.
REQ-017 wb_valid  output  1  writeback data present.
REQ-018 wb_ready  input  1  writeback consumer accepts.
REQ-019 wb_data  output  WIDTH  captured result.
REQ-020 wb_rd  output  5  destination tag of wb_data.
REQ-021 wb_error  output  1  operation timed out; wb_data is 0.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states IDLE, EXEC, WB; all outputs registered except req_ready and busy, which decode state.
REQ-024 req_ready = 1 only in IDLE; handshake fires on req_valid & req_ready at a rising edge.
REQ-025 On handshake: latch req_rs1/req_rs2 into fpu_operand_1/2, req_op into fpu_operation and an internal op register, req_rd into wb_rd; clear cycle counter; go to EXEC.
REQ-026 fpu_operand_1/2 hold stable from handshake until the next handshake.
REQ-027 In IDLE and WB, fpu_operation = FPU_ADD; in EXEC it equals the latched op.
REQ-028 In EXEC, the 8-bit counter increments every cycle, first EXEC cycle has count 0, saturates at 255.
REQ-029 Minimum latency: ADD/SUB 0, MUL MUL_MIN, SQRT SQRT_MIN; fpu_ready is ignored while count < minimum (it may be stale from a previous operation).
REQ-030 Completion: in EXEC with fpu_ready=1 and count >= minimum, capture fpu_result into wb_data, wb_error=0, go to WB.
REQ-031 Timeout: in EXEC with count == TIMEOUT and no completion that cycle, set wb_data=0, wb_error=1, go to WB; completion wins if both coincide.
REQ-032 In WB wb_valid=1; wb_data, wb_rd and wb_error hold stable until wb_ready=1, then next edge returns to IDLE with wb_valid=0.
REQ-033 No request is accepted in EXEC or WB; req_valid is ignored there.
REQ-034 ADD with wb_ready tied high: handshake edge N, EXEC cycle N+1, wb_valid high cycle N+2, req_ready high again cycle N+3.

Reset
REQ-035 Reset forces IDLE immediately, any cycle including mid-EXEC or WB; pending operation discarded, no writeback produced.
REQ-036 Reset values: wb_valid 0, wb_error 0, wb_data 0, wb_rd 0, fpu_operand_1/2 0, fpu_operation FPU_ADD, counter 0, busy 0, req_ready 1 after reset deasserts.

Verification
REQ-037 ADD 0x00000C00 + 0x00000400, FPU stub ready=1 always, wb_ready=1 -> wb_valid on 2nd cycle after handshake, wb_data 0x00001000, wb_error 0.
REQ-038 MUL 0x00000800 x 0x00000C00, stub ready held 1 from start, result 0x00000600 -> ready ignored for counts 0..6, wb_data 0x00000600 captured at count 7.
REQ-039 SQRT, stub never asserts ready, TIMEOUT=255 -> wb_valid with wb_error 1, wb_data 0 after count 255.
REQ-040 SUB completes, wb_ready held 0 for 5 cycles while req_valid=1 -> wb_valid/wb_data/wb_rd stable, req_ready 0 throughout, no second handshake until one cycle after wb_ready.
REQ-041 Reset pulsed at count 10 of a MUL -> outputs at REQ-036 values immediately, no wb_valid, next ADD completes normally.
